// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline definitions
// Purpose: decode-control bit positions, EXE_CMD codes, shift-type codes and
//          the CPSR flag layout used by the IF, ID and EXE stages.
// Ports:   none (package).
package arm_pkg;

  localparam int CTRL_W        = 10;
  localparam int CTRL_WB_EN    = 9;
  localparam int CTRL_MEM_R_EN = 8;
  localparam int CTRL_MEM_W_EN = 7;
  localparam int CTRL_CMD_HI   = 6;
  localparam int CTRL_CMD_LO   = 3;
  localparam int CTRL_B        = 2;
  localparam int CTRL_S        = 1;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/val2_generator.sv
// rtl/val2_generator.sv - second ALU operand generator
// Purpose: builds Val2 from Rm / the 12-bit shifter operand field.
// Ports:   rm            Rm value
//          shift_operand instruction bits [11:0]
//          imm           I bit
//          mem_access    LDR/STR in flight (12-bit unsigned offset)
//          val2          selected operand (combinational)
module val2_generator
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rm,
  input  logic [11:0]      shift_operand,
  input  logic             imm,
  input  logic             mem_access,
  output logic [WIDTH-1:0] val2
);

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] imm_rotated;
  logic [WIDTH-1:0] rm_shifted;
  logic [4:0]       imm_rot;
  logic [5:0]       imm_rot_inv;
  logic [4:0]       shift_amt;
  logic [5:0]       shift_amt_inv;
  shift_t           shift_type;

  assign imm_ext       = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
  assign imm_rot       = {shift_operand[11:8], 1'b0};
  assign imm_rot_inv   = 6'(WIDTH) - {1'b0, imm_rot};
  assign shift_amt     = shift_operand[11:7];
  assign shift_amt_inv = 6'(WIDTH) - {1'b0, shift_amt};
  assign shift_type    = shift_t'(shift_operand[6:5]);

  // A left shift by the full width yields zero, so a rotate of 0 is identity.
  assign imm_rotated = (imm_ext >> imm_rot) | (imm_ext << imm_rot_inv);

  always_comb begin
    rm_shifted = rm;
    case (shift_type)
      SHIFT_LSL: rm_shifted = rm << shift_amt;
      SHIFT_LSR: rm_shifted = rm >> shift_amt;
      SHIFT_ASR: rm_shifted = $unsigned($signed(rm) >>> shift_amt);
      SHIFT_ROR: rm_shifted = (rm >> shift_amt) | (rm << shift_amt_inv);
      default:   rm_shifted = rm;
    endcase
  end

  assign val2 = mem_access ? {{(WIDTH-12){1'b0}}, shift_operand} :
                imm        ? imm_rotated : rm_shifted;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM pipeline execute stage
// Purpose: ID/EXE register, Val2 generator, ALU, CPSR and EXE/MEM register.
// Ports:   clk, rst (async active-low)
//          ctrl_in, pc_in, rn_in, rm_in, imm_in, shift_operand_in,
//          signed_imm_in, dest_in           decode-stage inputs
//          branch_taken, branch_address     back to instruction fetch
//          c_out, v_out, z_out, n_out       CPSR back to instruction decode
//          wb_en_out, mem_r_en_out, mem_w_en_out, alu_result_out,
//          st_val_out, dest_out             EXE/MEM register
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CTRL_W-1:0]   ctrl_in,
  input  logic [WIDTH-1:0]    pc_in,
  input  logic [WIDTH-1:0]    rn_in,
  input  logic [WIDTH-1:0]    rm_in,
  input  logic                imm_in,
  input  logic [11:0]         shift_operand_in,
  input  logic [23:0]         signed_imm_in,
  input  logic [REG_ADDR-1:0] dest_in,
  output logic                branch_taken,
  output logic [WIDTH-1:0]    branch_address,
  output logic                c_out,
  output logic                v_out,
  output logic                z_out,
  output logic                n_out,
  output logic                wb_en_out,
  output logic                mem_r_en_out,
  output logic                mem_w_en_out,
  output logic [WIDTH-1:0]    alu_result_out,
  output logic [WIDTH-1:0]    st_val_out,
  output logic [REG_ADDR-1:0] dest_out
);

  // ID/EXE register
  logic                id_wb, id_mr, id_mw, id_b, id_s, id_imm;
  logic [3:0]          id_cmd;
  logic [WIDTH-1:0]    id_pc, id_rn, id_rm;
  logic [11:0]         id_shop;
  logic [23:0]         id_simm;
  logic [REG_ADDR-1:0] id_dest;

  flags_t           cpsr, flags_next;
  logic [WIDTH-1:0] val2, operand_b, alu_result;
  logic [WIDTH:0]   sum;
  logic             carry_in, arith, logical;

  logic unused_reserved;
  assign unused_reserved = ctrl_in[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || branch_taken) begin
      // A taken branch squashes the instruction fetched behind it.
      id_wb   <= 1'b0;
      id_mr   <= 1'b0;
      id_mw   <= 1'b0;
      id_cmd  <= '0;
      id_b    <= 1'b0;
      id_s    <= 1'b0;
      id_pc   <= '0;
      id_rn   <= '0;
      id_rm   <= '0;
      id_imm  <= 1'b0;
      id_shop <= '0;
      id_simm <= '0;
      id_dest <= '0;
    end else begin
      id_wb   <= ctrl_in[CTRL_WB_EN];
      id_mr   <= ctrl_in[CTRL_MEM_R_EN];
      id_mw   <= ctrl_in[CTRL_MEM_W_EN];
      id_cmd  <= ctrl_in[CTRL_CMD_HI:CTRL_CMD_LO];
      id_b    <= ctrl_in[CTRL_B];
      id_s    <= ctrl_in[CTRL_S];
      id_pc   <= pc_in;
      id_rn   <= rn_in;
      id_rm   <= rm_in;
      id_imm  <= imm_in;
      id_shop <= shift_operand_in;
      id_simm <= signed_imm_in;
      id_dest <= dest_in;
    end
  end

  assign branch_taken   = id_b;
  assign branch_address = id_pc + {{(WIDTH-26){id_simm[23]}}, id_simm, 2'b00};

  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .rm            (id_rm),
    .shift_operand (id_shop),
    .imm           (id_imm),
    .mem_access    (id_mr | id_mw),
    .val2          (val2)
  );

  // One adder serves all four arithmetic ops: subtract is Rn + ~Val2 + 1,
  // and SBC's "- !C" folds into the carry-in, so C is directly NOT borrow.
  always_comb begin
    alu_result = '0;
    flags_next = cpsr;
    operand_b  = val2;
    carry_in   = 1'b0;
    arith      = 1'b0;
    logical    = 1'b0;
    case (id_cmd)
      EXE_MOV: begin logical = 1'b1; alu_result = val2;          end
      EXE_MVN: begin logical = 1'b1; alu_result = ~val2;         end
      EXE_AND: begin logical = 1'b1; alu_result = id_rn & val2;  end
      EXE_ORR: begin logical = 1'b1; alu_result = id_rn | val2;  end
      EXE_EOR: begin logical = 1'b1; alu_result = id_rn ^ val2;  end
      EXE_ADD: begin arith = 1'b1;                               end
      EXE_ADC: begin arith = 1'b1; carry_in = cpsr.c;            end
      EXE_SUB: begin arith = 1'b1; operand_b = ~val2; carry_in = 1'b1;   end
      EXE_SBC: begin arith = 1'b1; operand_b = ~val2; carry_in = cpsr.c; end
      default: ;
    endcase
    sum = {1'b0, id_rn} + {1'b0, operand_b} + {{WIDTH{1'b0}}, carry_in};
    if (arith) begin
      alu_result = sum[WIDTH-1:0];
    end
    if (arith || logical) begin
      flags_next.n = alu_result[WIDTH-1];
      flags_next.z = (alu_result == '0);
    end
    if (arith) begin
      flags_next.c = sum[WIDTH];
      flags_next.v = (id_rn[WIDTH-1] == operand_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != id_rn[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpsr <= '0;
    end else if (id_s) begin
      cpsr <= flags_next;
    end
  end

  assign c_out = cpsr.c;
  assign v_out = cpsr.v;
  assign z_out = cpsr.z;
  assign n_out = cpsr.n;

  // EXE/MEM register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      mem_w_en_out   <= 1'b0;
      alu_result_out <= '0;
      st_val_out     <= '0;
      dest_out       <= '0;
    end else begin
      wb_en_out      <= id_wb;
      mem_r_en_out   <= id_mr;
      mem_w_en_out   <= id_mw;
      alu_result_out <= alu_result;
      st_val_out     <= id_rm;
      dest_out       <= id_dest;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage
module tb_exe_stage;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  ctrl_in;
  logic [31:0] pc_in, rn_in, rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_in;
  logic [3:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        c_out, v_out, z_out, n_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_result_out, st_val_out;
  logic [3:0]  dest_out;

  exe_stage #(.WIDTH(32), .REG_ADDR(4)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .pc_in(pc_in), .rn_in(rn_in),
    .rm_in(rm_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_in(signed_imm_in), .dest_in(dest_in),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .c_out(c_out), .v_out(v_out), .z_out(z_out), .n_out(n_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_result_out(alu_result_out), .st_val_out(st_val_out), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] res, st;
    logic [3:0]  dest;
    logic        wb, mr, mw;
    logic [3:0]  nzcv;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  instr_t      m_id;
  logic [3:0]  m_nzcv;
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest;

  function automatic logic [9:0] cb(logic wb, logic mr, logic mw, logic [3:0] cmd,
                                    logic b, logic s);
    return {wb, mr, mw, cmd, b, s, 1'b0};
  endfunction

  function automatic instr_t mk(logic [9:0] c, logic [31:0] rn, logic [31:0] rm,
                                logic imm, logic [11:0] shop, logic [3:0] dest);
    instr_t x;
    x.ctrl = c; x.pc = 32'd0; x.rn = rn; x.rm = rm; x.imm = imm;
    x.shop = shop; x.simm = 24'd0; x.dest = dest;
    return x;
  endfunction

  function automatic logic [31:0] ref_val2(instr_t i);
    logic [31:0] x;
    int amt;
    if (i.ctrl[8] || i.ctrl[7]) return {20'd0, i.shop};
    if (i.imm) begin
      x = {24'd0, i.shop[7:0]};
      amt = 2 * int'(i.shop[11:8]);
      for (int k = 0; k < amt; k++) x = {x[0], x[31:1]};
      return x;
    end
    x = i.rm;
    amt = int'(i.shop[11:7]);
    for (int k = 0; k < amt; k++) begin
      case (i.shop[6:5])
        2'b00:   x = {x[30:0], 1'b0};
        2'b01:   x = {1'b0, x[31:1]};
        2'b10:   x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    end
    return x;
  endfunction

  task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v,
                         input logic [3:0] fin, output logic [31:0] res, output logic [3:0] fo);
    longint u, s, urn, uv, srn, sv, c;
    bit arith, valid, cnew;
    urn = longint'(rn); uv = longint'(v);
    srn = longint'($signed(rn)); sv = longint'($signed(v));
    c = longint'(fin[1]);
    arith = 0; valid = 1; cnew = 0; u = 0; s = 0;
    fo = fin; res = 32'd0;
    case (cmd)
      EXE_MOV: res = v;
      EXE_MVN: res = ~v;
      EXE_AND: res = rn & v;
      EXE_ORR: res = rn | v;
      EXE_EOR: res = rn ^ v;
      EXE_ADD: begin arith = 1; u = urn + uv;     s = srn + sv;     cnew = (u >= 64'sd4294967296); end
      EXE_ADC: begin arith = 1; u = urn + uv + c; s = srn + sv + c; cnew = (u >= 64'sd4294967296); end
      EXE_SUB: begin arith = 1; u = urn - uv;     s = srn - sv;     cnew = (u >= 0); end
      EXE_SBC: begin arith = 1; u = urn - uv - (1 - c); s = srn - sv - (1 - c); cnew = (u >= 0); end
      default: valid = 0;
    endcase
    if (arith) res = u[31:0];
    if (valid) begin
      fo[3] = res[31];
      fo[2] = (res == 32'd0);
      if (arith) begin
        fo[1] = cnew;
        fo[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    end
  endtask

  task automatic model_reset();
    m_id = '{default: '0};
    m_nzcv = 4'd0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_res = 32'd0; m_st = 32'd0; m_dest = 4'd0;
  endtask

  task automatic model_edge(input instr_t x);
    logic [31:0] res;
    logic [3:0]  f;
    ref_alu(m_id.ctrl[6:3], m_id.rn, ref_val2(m_id), m_nzcv, res, f);
    m_wb = m_id.ctrl[9]; m_mr = m_id.ctrl[8]; m_mw = m_id.ctrl[7];
    m_res = res; m_st = m_id.rm; m_dest = m_id.dest;
    if (m_id.ctrl[1]) m_nzcv = f;
    if (m_id.ctrl[2]) m_id = '{default: '0};
    else m_id = x;
  endtask

  function automatic logic [127:0] model_vec();
    logic [31:0] ba;
    ba = m_id.pc + 32'(longint'($signed(m_id.simm)) * 4);
    return {20'd0, m_id.ctrl[2], ba, m_nzcv, m_wb, m_mr, m_mw, m_res, m_st, m_dest};
  endfunction

  function automatic logic [127:0] dut_vec();
    return {20'd0, branch_taken, branch_address, n_out, z_out, c_out, v_out,
            wb_en_out, mem_r_en_out, mem_w_en_out, alu_result_out, st_val_out, dest_out};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t x);
    ctrl_in = x.ctrl; pc_in = x.pc; rn_in = x.rn; rm_in = x.rm; imm_in = x.imm;
    shift_operand_in = x.shop; signed_imm_in = x.simm; dest_in = x.dest;
  endtask

  task automatic tick(input instr_t x);
    drive(x);
    @(posedge clk);
    model_edge(x);
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t x;
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h7FFFFFFF; edge_vals[1] = 32'h80000000;
    edge_vals[2] = 32'hFFFFFFFF; edge_vals[3] = 32'h00000000;
    x.ctrl = 10'($urandom);
    x.ctrl[2] = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 2) != 0) x.ctrl[8:7] = 2'b00;
    x.pc = $urandom; x.rn = $urandom; x.rm = $urandom;
    if ($urandom_range(0, 3) == 0) x.rn = edge_vals[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) x.rm = edge_vals[$urandom_range(0, 3)];
    x.imm = 1'($urandom);
    x.shop = 12'($urandom);
    x.simm = 24'($urandom);
    x.dest = 4'($urandom);
    return x;
  endfunction

  vec_t   vt [13];
  instr_t nop, bi;

  initial begin
    nop = '{default: '0};
    model_reset();
    vt[0]  = '{mk(cb(1,0,0,EXE_ADD,0,1), 32'd5, 32'd0, 1, 12'h0FF, 4'd3), 32'd260, 32'd0, 4'd3, 1,0,0, 4'b0000};
    vt[1]  = '{mk(cb(1,0,0,EXE_SUB,0,1), 32'd5, 32'd0, 1, 12'h005, 4'd4), 32'd0, 32'd0, 4'd4, 1,0,0, 4'b0110};
    vt[2]  = '{mk(cb(1,0,0,EXE_ADD,0,1), 32'h7FFFFFFF, 32'd0, 1, 12'h001, 4'd5), 32'h80000000, 32'd0, 4'd5, 1,0,0, 4'b1001};
    vt[3]  = '{mk(cb(1,0,0,EXE_MOV,0,0), 32'd0, 32'd0, 1, 12'h1F0, 4'd1), 32'h0000003C, 32'd0, 4'd1, 1,0,0, 4'b1001};
    vt[4]  = '{mk(cb(1,0,0,EXE_MOV,0,1), 32'd0, 32'h80000000, 0, 12'h240, 4'd2), 32'hF8000000, 32'h80000000, 4'd2, 1,0,0, 4'b1001};
    vt[5]  = '{mk(cb(1,1,0,EXE_ADD,0,0), 32'd0, 32'h12345678, 0, 12'hFFF, 4'd6), 32'h00000FFF, 32'h12345678, 4'd6, 1,1,0, 4'b1001};
    vt[6]  = '{mk(cb(1,0,0,EXE_SUB,0,1), 32'd5, 32'd0, 1, 12'h005, 4'd4), 32'd0, 32'd0, 4'd4, 1,0,0, 4'b0110};
    vt[7]  = '{mk(cb(1,0,0,EXE_ADC,0,0), 32'd1, 32'd0, 1, 12'h001, 4'd7), 32'd3, 32'd0, 4'd7, 1,0,0, 4'b0110};
    vt[8]  = '{mk(cb(0,0,1,EXE_ADD,0,0), 32'h100, 32'hDEADBEEF, 0, 12'h004, 4'd8), 32'h104, 32'hDEADBEEF, 4'd8, 0,0,1, 4'b0110};
    vt[9]  = '{mk(cb(1,0,0,4'b1111,0,1), 32'h55, 32'd0, 1, 12'h0AA, 4'd9), 32'd0, 32'd0, 4'd9, 1,0,0, 4'b0110};
    vt[10] = '{mk(cb(1,0,0,EXE_MVN,0,1), 32'd0, 32'd0, 1, 12'h000, 4'd10), 32'hFFFFFFFF, 32'd0, 4'd10, 1,0,0, 4'b1010};
    vt[11] = '{mk(cb(1,0,0,EXE_SBC,0,1), 32'd10, 32'd0, 1, 12'h003, 4'd11), 32'd7, 32'd0, 4'd11, 1,0,0, 4'b0010};
    vt[12] = '{mk(cb(1,0,0,EXE_MOV,0,0), 32'd0, 32'h000000F1, 0, 12'h260, 4'd12), 32'h1000000F, 32'h000000F1, 4'd12, 1,0,0, 4'b0010};

    // Reset held with random inputs: everything reads zero.
    rst = 1'b0;
    drive(rand_instr());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", dut_vec(), 128'd0);
      drive(rand_instr());
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick(nop);
      check("after_reset", dut_vec(), 128'd0);
    end

    // Directed vectors, each followed by a NOP so results sit in EXE/MEM.
    for (int i = 0; i < 13; i++) begin
      tick(vt[i].in);
      tick(nop);
      check($sformatf("vec%0d", i),
            {53'd0, alu_result_out, st_val_out, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out,
             n_out, z_out, c_out, v_out},
            {53'd0, vt[i].res, vt[i].st, vt[i].dest, vt[i].wb, vt[i].mr, vt[i].mw, vt[i].nzcv});
    end

    // Branch: one-cycle branch_taken, following instruction squashed, CPSR kept.
    bi = mk(cb(0,0,0,4'b0000,1,0), 32'd0, 32'd0, 0, 12'h000, 4'd0);
    bi.pc = 32'h20; bi.simm = 24'hFFFFFE;
    tick(bi);
    check("branch_cycle1", {95'd0, branch_taken, branch_address}, {95'd0, 1'b1, 32'h18});
    tick(mk(cb(1,0,1,EXE_ADD,0,1), 32'd1, 32'd0, 1, 12'h001, 4'd2));
    check("branch_cycle2", {127'd0, branch_taken}, 128'd0);
    tick(nop);
    check("branch_bubble", {84'd0, wb_en_out, mem_w_en_out, alu_result_out, dest_out, n_out, z_out, c_out, v_out},
          {84'd0, 1'b0, 1'b0, 32'd0, 4'd0, 4'b0010});

    // Asynchronous reset mid-pipeline.
    tick(mk(cb(1,0,0,EXE_ADD,0,1), 32'd5, 32'd9, 1, 12'h0FF, 4'd3));
    tick(nop);
    check("pre_async_reset", dut_vec(), model_vec());
    #2 rst = 1'b0;
    #1 check("async_reset", dut_vec(), 128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();

    // Randomized stream against the reference model.
    for (int i = 0; i < 400; i++) begin
      tick(rand_instr());
      check("random", dut_vec(), model_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline, sitting between instruction decode and memory.
- Contains the ID/EXE pipeline register, the Val2 generator, the ALU, the CPSR status register and the EXE/MEM pipeline register.
- It is the far end of the decode stage's outputs. It returns branch_taken/branch_address to instruction fetch and the status bits C/V/Z/N to instruction decode, closing both loops.

Parameters:
- WIDTH, 32, datapath width (Rn, Rm, PC, results).
- REG_ADDR, 4, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ctrl_in  in  10  decode control: [9] WB_EN, [8] MEM_R_EN, [7] MEM_W_EN, [6:3] EXE_CMD, [2] B, [1] S, [0] reserved (ignored)
- pc_in  in  32  PC+4 of the decoded instruction
- rn_in  in  32  Rn value
- rm_in  in  32  Rm value
- imm_in  in  1  I bit
- shift_operand_in  in  12  instruction bits [11:0]
- signed_imm_in  in  24  branch offset
- dest_in  in  4  destination register
- branch_taken  out  1  to IF; combinational from the ID/EXE register
- branch_address  out  32  to IF
- c_out, v_out, z_out, n_out  out  1 each  CPSR bits to ID
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  EXE/MEM control
- alu_result_out  out  32  EXE/MEM
- st_val_out  out  32  Rm passed through for STR
- dest_out  out  4  EXE/MEM

Behaviour:
- Reset (rst=0, asynchronous): both pipeline registers and the CPSR clear to 0, so every output reads 0.
- Latency: inputs are captured at edge N. branch_taken/branch_address are valid during cycle N+1. EXE/MEM outputs and the CPSR update at edge N+1.
- Flush: when branch_taken=1 at an edge, the ID/EXE register loads a bubble (all ctrl 0, other fields 0) instead of ctrl_in. branch_taken therefore lasts exactly one cycle per branch.
- branch_taken is the registered B bit.
- branch_address = pc + (sign-extend(signed_imm) << 2), modulo 2^32.
- Val2 selection:
  - MEM_R_EN or MEM_W_EN set: zero-extended shift_operand[11:0].
  - Else if I=1: ROR({24'b0, imm8 = [7:0]}, 2*[11:8]).
  - Else: Rm shifted by [11:7] using type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 leaves the value unchanged.
- EXE_CMD operations:
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD = Rn+Val2 (also used by LDR/STR)
  - 0011 ADC = Rn+Val2+C
  - 0100 SUB/CMP = Rn-Val2
  - 0101 SBC = Rn-Val2-!C
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - any other code: result 0, flags unchanged
- Flag rules:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry out (for subtract, C = NOT borrow); V = signed overflow.
  - Logical and move ops leave C and V unchanged.
- ADC/SBC use the CPSR value current in that cycle, i.e. the value before this instruction's update.
- The CPSR latches the new flags at the edge only when the registered S=1; otherwise it holds.
- The CPSR is not written by bubbles. It is not written by a branch unless S=1.
- The EXE/MEM register always captures: ctrl bits, ALU result, Rm, dest.

Decomposition:
- Shared package arm_pkg holds the EXE_CMD localparams, the ctrl bit indices and the shift-type codes. IF, ID and EXE all use it.
- One natural sub-module: val2_generator, which is combinational and takes Rm, shift_operand, I and the memory flag.
- The ALU stays inline.

Test Plan:
- Reset: hold rst=0 with random inputs applied → all outputs 0. Release rst → outputs stay 0 until the first valid instruction.
- ADDS immediate: Rn=5, I=1, shift_operand=0x0FF, EXE_CMD=0010, S=1, dest=3, WB_EN=1 → after 2 edges alu_result_out=260, dest_out=3, wb_en_out=1, NZCV=0000.
- SUBS 5-5, then ADDS 0x7FFFFFFF+1 → Z=1 C=1 after the first; then N=1 V=1 Z=0 C=0.
- Val2 generation:
  - I=1, shift_operand=0x1F0 → Val2=0x3C.
  - I=0, Rm=0x80000000, shift_operand=0x240 (ASR #4) → MOV result 0xF8000000.
  - LDR with offset 0xFFF → Val2=0x00000FFF.
- Branch: B=1, pc_in=0x20, signed_imm=0xFFFFFE → branch_taken=1 for exactly one cycle with branch_address=0x18. The following instruction becomes a bubble (wb_en_out=0, mem_w_en_out=0), and the CPSR is unchanged.
- Carry chain and reset mid-operation:
  - ADC with C=1: Rn=1, Val2=1 → 3.
  - Assert rst mid-pipeline → outputs clear immediately, without waiting for a clock edge.
